// File: rtl/eth_pkg.sv
// Shared word layout and write-FSM state type for the Ethernet receive path.
// Word layout: {end, start, data[31:0]}.
package eth_pkg;

  localparam int ETH_WORD_W    = 34;
  localparam int ETH_DATA_W    = 32;
  localparam int ETH_START_BIT = 32;
  localparam int ETH_END_BIT   = 33;

  typedef enum logic [1:0] {IDLE, WRITE, DROP} pkt_fifo_state_t;

  typedef logic [ETH_WORD_W-1:0] eth_word_t;

endpackage

// File: rtl/eth_fifo_ram.sv
// Simple dual-port RAM, DEPTH x 34 bits: synchronous write, registered read.
// The read register holds its value when rd_en is low.
module eth_fifo_ram
  import eth_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [ETH_WORD_W-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [ETH_WORD_W-1:0] rd_data
);

  eth_word_t mem [DEPTH];

  // NOTE: the storage array has no reset; only the read register does, so the
  // array can map onto block RAM and reset fan-out stays small.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_rx_pkt_fifo.sv
// Packet-aware store-and-forward FIFO behind the Ethernet receiver.
// Optional `ETH_RX_PKT_FIFO_STATS_EN adds the saturating drop_cnt port.
module eth_rx_pkt_fifo
  import eth_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ETH_WORD_W-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [ETH_WORD_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic                  empty,
  output logic                  drop
`ifdef ETH_RX_PKT_FIFO_STATS_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  pkt_fifo_state_t  state, state_n;
  logic [CNT_W-1:0] wr_ptr, wr_ptr_n;
  logic [CNT_W-1:0] cm_ptr, cm_ptr_n;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] base_ptr;
  logic             base_full;
  logic             drop_n;
  logic             commit;
  logic             mem_we;
  logic             wr_start, wr_end;
  logic             rd_accept, rd_end;
  logic [DEPTH-1:0] end_mark;

  assign wr_start  = wr_data[ETH_START_BIT];
  assign wr_end    = wr_data[ETH_END_BIT];
  assign empty     = (cm_ptr == rd_ptr);
  assign rd_accept = rd_en && !empty;
  assign rd_end    = end_mark[rd_ptr[AW-1:0]];

  // base_ptr is where the current word lands: the committed pointer when a
  // restart abandons an open packet, otherwise the tentative write pointer.
  // Fullness uses the pre-read rd_ptr, which is conservative.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_n   = state;
    wr_ptr_n  = wr_ptr;
    cm_ptr_n  = cm_ptr;
    drop_n    = 1'b0;
    commit    = 1'b0;
    mem_we    = 1'b0;
    base_ptr  = wr_ptr;
    if (wr_en && state == WRITE && wr_start) begin
      base_ptr = cm_ptr;
      wr_ptr_n = cm_ptr;
      drop_n   = 1'b1;
    end
    base_full = ((base_ptr - rd_ptr) == CNT_W'(DEPTH));

    if (wr_en) begin
      if (wr_start) begin
        if (base_full) begin
          drop_n   = 1'b1;
          wr_ptr_n = base_ptr;
          state_n  = wr_end ? IDLE : DROP;
        end else begin
          mem_we   = 1'b1;
          wr_ptr_n = base_ptr + 1'b1;
          if (wr_end) begin
            cm_ptr_n = base_ptr + 1'b1;
            commit   = 1'b1;
            state_n  = IDLE;
          end else begin
            state_n  = WRITE;
          end
        end
      end else begin
        case (state)
          IDLE: state_n = IDLE;
          WRITE: begin
            if (base_full) begin
              drop_n   = 1'b1;
              wr_ptr_n = cm_ptr;
              state_n  = wr_end ? IDLE : DROP;
            end else begin
              mem_we   = 1'b1;
              wr_ptr_n = base_ptr + 1'b1;
              if (wr_end) begin
                cm_ptr_n = base_ptr + 1'b1;
                commit   = 1'b1;
                state_n  = IDLE;
              end
            end
          end
          DROP:    if (wr_end) state_n = IDLE;
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
      drop   <= 1'b0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr_n;
      cm_ptr <= cm_ptr_n;
      drop   <= drop_n;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      rd_valid <= rd_accept;
      case ({commit, rd_accept && rd_end})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Shadow of each word's end bit so pkt_cnt can drop at read acceptance,
  // before the registered RAM output appears.
  always_ff @(posedge clk) begin
    if (mem_we) end_mark[base_ptr[AW-1:0]] <= wr_end;
  end

`ifdef ETH_RX_PKT_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              drop_cnt <= '0;
    else if (drop_n && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
  end
`endif

  eth_fifo_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(AW)
  ) u_ram (
    .clk    (clk),
    .rstn   (rstn),
    .wr_en  (mem_we),
    .wr_addr(base_ptr[AW-1:0]),
    .wr_data(wr_data),
    .rd_en  (rd_accept),
    .rd_addr(rd_ptr[AW-1:0]),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_eth_rx_pkt_fifo.sv
// Directed bench for eth_rx_pkt_fifo: a per-cycle vector table followed by
// hand-written fill, oversize, reset and forced-drop sequences.
module tb_eth_rx_pkt_fifo;

  localparam int DEPTH = 64;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rstn;
  logic [33:0]      wr_data;
  logic             wr_en;
  logic             rd_en;
  logic [33:0]      rd_data;
  logic             rd_valid;
  logic [CNT_W-1:0] pkt_cnt;
  logic             empty;
  logic             drop;
`ifdef ETH_RX_PKT_FIFO_STATS_EN
  logic [15:0]      drop_cnt;
`endif

  eth_rx_pkt_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .pkt_cnt (pkt_cnt),
    .empty   (empty),
    .drop    (drop)
`ifdef ETH_RX_PKT_FIFO_STATS_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [33:0] wr_data;
    logic        rd_en;
    logic        rd_valid;
    logic [33:0] rd_data;
    logic [6:0]  pkt_cnt;
    logic        empty;
    logic        drop;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   drop_seen = 0;

  always @(negedge clk) if (rstn && drop) drop_seen++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cycle(input logic we, input logic [33:0] wd, input logic re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [33:0] wd, input logic re,
                              input logic v, input logic [33:0] rd, input logic [6:0] pc,
                              input logic e, input logic d);
    vec_t t;
    t.wr_en = we; t.wr_data = wd; t.rd_en = re;
    t.rd_valid = v; t.rd_data = rd; t.pkt_cnt = pc; t.empty = e; t.drop = d;
    return t;
  endfunction

  function automatic logic [33:0] fw(input int p, input int j);
    return {j == 3, j == 0, 32'hF000_0000 | 32'(p << 8) | 32'(j)};
  endfunction

  initial begin
    logic [33:0] w0, w1, w2, w3, sw, a1, a2, b0, b1, b2, c0, c1, c2, ew;
    int d0;

    w0 = 34'h1_1111_0000; w1 = 34'h0_1111_0001; w2 = 34'h0_1111_0002; w3 = 34'h2_1111_0003;
    sw = 34'h3_DEAD_BEEF; a1 = 34'h3_A5A5_0001; a2 = 34'h3_A5A5_0002;
    b0 = 34'h1_B0B0_0000; b1 = 34'h0_B0B0_0001; b2 = 34'h0_B0B0_0002;
    c0 = 34'h1_C0C0_0000; c1 = 34'h0_C0C0_0001; c2 = 34'h2_C0C0_0002;
    ew = 34'h2_EEEE_EEEE;

    // 4-word packet with rd_en held high, single-word packet, commit+read
    // collision, restart mid-packet, and an orphan end word in IDLE.
    vecs.push_back(mk(1, w0, 1, 0, 34'h0, 0, 1, 0));
    vecs.push_back(mk(1, w1, 1, 0, 34'h0, 0, 1, 0));
    vecs.push_back(mk(1, w2, 1, 0, 34'h0, 0, 1, 0));
    vecs.push_back(mk(1, w3, 1, 0, 34'h0, 1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 1, w0,    1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 1, w1,    1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 1, w2,    1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 1, w3,    0, 1, 0));
    vecs.push_back(mk(0, 0,  1, 0, w3,    0, 1, 0));
    vecs.push_back(mk(1, sw, 0, 0, w3,    1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 1, sw,    0, 1, 0));
    vecs.push_back(mk(1, a1, 0, 0, sw,    1, 0, 0));
    vecs.push_back(mk(1, a2, 1, 1, a1,    1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 1, a2,    0, 1, 0));
    vecs.push_back(mk(1, b0, 0, 0, a2,    0, 1, 0));
    vecs.push_back(mk(1, b1, 0, 0, a2,    0, 1, 0));
    vecs.push_back(mk(1, b2, 0, 0, a2,    0, 1, 0));
    vecs.push_back(mk(1, c0, 0, 0, a2,    0, 1, 1));
    vecs.push_back(mk(1, c1, 0, 0, a2,    0, 1, 0));
    vecs.push_back(mk(1, c2, 0, 0, a2,    1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 1, c0,    1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 1, c1,    1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 1, c2,    0, 1, 0));
    vecs.push_back(mk(1, ew, 0, 0, c2,    0, 1, 0));
    vecs.push_back(mk(0, 0,  1, 0, c2,    0, 1, 0));

    rstn = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_data", rd_data, 0);
    check("reset pkt_cnt", pkt_cnt, 0);
    check("reset empty", empty, 1);
    check("reset drop", drop, 0);
`ifdef ETH_RX_PKT_FIFO_STATS_EN
    check("reset drop_cnt", drop_cnt, 0);
`endif

    foreach (vecs[i]) begin
      cycle(vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_en);
      check($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].rd_valid);
      check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].rd_data);
      check($sformatf("vec%0d pkt_cnt", i), pkt_cnt, vecs[i].pkt_cnt);
      check($sformatf("vec%0d empty", i), empty, vecs[i].empty);
      check($sformatf("vec%0d drop", i), drop, vecs[i].drop);
    end

    // 60 committed words, then a 10-word packet that overflows on word 5.
    for (int p = 0; p < 15; p++)
      for (int j = 0; j < 4; j++) cycle(1, fw(p, j), 0);
    check("fill pkt_cnt", pkt_cnt, 15);
    check("fill empty", empty, 0);
    for (int j = 0; j < 10; j++) begin
      cycle(1, {j == 9, j == 0, 32'h0F0F_0000 + 32'(j)}, 0);
      check($sformatf("ovf drop w%0d", j), drop, j == 4);
    end
    check("ovf pkt_cnt", pkt_cnt, 15);
    for (int k = 0; k < 60; k++) begin
      cycle(0, 0, 1);
      check($sformatf("drain%0d valid", k), rd_valid, 1);
      check($sformatf("drain%0d data", k), rd_data, fw(k / 4, k % 4));
    end
    check("drain empty", empty, 1);
    check("drain pkt_cnt", pkt_cnt, 0);
    cycle(1, 34'h1_3333_0000, 0);
    cycle(1, 34'h0_3333_0001, 0);
    cycle(1, 34'h2_3333_0002, 0);
    check("post3 pkt_cnt", pkt_cnt, 1);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 1);
      check($sformatf("post3 data%0d", k), rd_data,
            {k == 2, k == 0, 32'h3333_0000 + 32'(k)});
    end
    check("post3 empty", empty, 1);

    // 70-word packet into an empty FIFO is dropped whole.
    d0 = drop_seen;
    for (int j = 0; j < 70; j++) cycle(1, {j == 69, j == 0, 32'h7070_0000 + 32'(j)}, 0);
    cycle(0, 0, 0);
    check("long drop pulses", drop_seen - d0, 1);
    check("long pkt_cnt", pkt_cnt, 0);
    check("long empty", empty, 1);
    cycle(1, 34'h1_4444_0000, 0);
    cycle(1, 34'h2_4444_0001, 0);
    check("after long pkt_cnt", pkt_cnt, 1);
    cycle(0, 0, 1);
    check("after long w0", rd_data, 34'h1_4444_0000);
    cycle(0, 0, 1);
    check("after long w1", rd_data, 34'h2_4444_0001);
    check("after long empty", empty, 1);

    // Asynchronous reset mid-packet with two packets committed.
    cycle(1, 34'h3_5555_0001, 0);
    cycle(1, 34'h3_5555_0002, 0);
    cycle(1, 34'h1_5555_0003, 0);
    cycle(1, 34'h0_5555_0004, 0);
    check("prerst pkt_cnt", pkt_cnt, 2);
    wr_en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("midrst empty", empty, 1);
    check("midrst pkt_cnt", pkt_cnt, 0);
    check("midrst rd_valid", rd_valid, 0);
    check("midrst rd_data", rd_data, 0);
`ifdef ETH_RX_PKT_FIFO_STATS_EN
    check("midrst drop_cnt", drop_cnt, 0);
`endif
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    cycle(0, 0, 1);
    check("postrst rd_valid", rd_valid, 0);
    check("postrst empty", empty, 1);

    // 300 forced drops via repeated restarts, then the last packet commits.
    d0 = drop_seen;
    cycle(1, 34'h1_5000_0000, 0);
    for (int i = 1; i <= 300; i++) cycle(1, {2'b01, 32'h5000_0000 + 32'(i)}, 0);
    cycle(1, 34'h2_5EED_0000, 0);
    cycle(0, 0, 0);
    check("forced drop pulses", drop_seen - d0, 300);
`ifdef ETH_RX_PKT_FIFO_STATS_EN
    check("forced drop_cnt", drop_cnt, 300);
`endif
    check("forced pkt_cnt", pkt_cnt, 1);
    cycle(0, 0, 1);
    check("forced w0", rd_data, 34'h1_5000_012C);
    cycle(0, 0, 1);
    check("forced w1", rd_data, 34'h2_5EED_0000);
    check("forced final pkt_cnt", pkt_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_rx_pkt_fifo.md
Name: eth_rx_pkt_fifo

Overview:
Packet-aware store-and-forward FIFO that sits directly downstream of the Ethernet receiver. It accepts that stage's 34-bit write stream, which has no backpressure. A packet becomes visible to the read side only after its end word has been written. A packet that cannot fit is dropped whole, so the switch fabric never sees a partial packet.

Parameters:
DEPTH, 64, number of 34-bit word entries; must be a power of 2, minimum 4.
CNT_W, $clog2(DEPTH)+1, width of pointers (with wrap bit) and of pkt_cnt.

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
wr_data  input  34  {end, start, data[31:0]}; bit 33 = end, bit 32 = start
wr_en  input  1  write strobe from receiver; no backpressure exists
rd_en  input  1  read request from the switch fabric
rd_data  output  34  read word, same layout as wr_data
rd_valid  output  1  rd_data holds a valid word
pkt_cnt  output  CNT_W  number of complete packets stored
empty  output  1  no committed words available
drop  output  1  one-cycle pulse when a packet is discarded
drop_cnt  output  16  saturating dropped-packet count (only with ETH_RX_PKT_FIFO_STATS_EN)

Behaviour:
- Reset: clk is the clock; reset is rstn, asynchronous, active-low. Reset clears all pointers, the state, rd_data, rd_valid, pkt_cnt and drop (rd_data=0, rd_valid=0, pkt_cnt=0, drop=0), sets empty=1, and clears drop_cnt. A reset asserted mid-packet discards all content, including committed packets.
- Pointers (all CNT_W wide, wrapping naturally):
  - wr_ptr: tentative write pointer.
  - cm_ptr: committed write pointer.
  - rd_ptr: read pointer.
  - full = (wr_ptr - rd_ptr) == DEPTH.
  - empty = (cm_ptr == rd_ptr).
- Write FSM states: IDLE, WRITE, DROP.
- In IDLE, on wr_en:
  - start=0: the word is discarded silently.
  - start=1 and not full: store the word and wr_ptr++. If end=1, commit immediately (cm_ptr <= wr_ptr+1, pkt_cnt++) and stay in IDLE; otherwise go to WRITE.
  - start=1 and full: drop pulse. Go to IDLE if end=1, else go to DROP.
- In WRITE, on wr_en:
  - not full, start=0: store the word and wr_ptr++. If end=1, commit and go to IDLE.
  - full: rewind wr_ptr <= cm_ptr and pulse drop. Go to IDLE if end=1, else go to DROP.
  - start=1 (restart without a preceding end): rewind wr_ptr <= cm_ptr, pulse drop, then process the word exactly as IDLE would in the same cycle.
- In DROP: words are ignored. A word with end=1 returns the FSM to IDLE. A word with start=1 is processed as in IDLE.
- A packet longer than DEPTH words is always dropped.
- Read side (1-cycle latency): rd_en while !empty reads mem[rd_ptr], rd_ptr++, and sets rd_valid=1 on the next cycle. rd_en while empty is ignored and rd_valid=0 next cycle. rd_data holds its last value while rd_valid=0.
- pkt_cnt:
  - increments on commit;
  - decrements when a word with end=1 is read (the decrement happens at read acceptance);
  - a commit and an end-word read in the same cycle leave pkt_cnt unchanged.
- A read and a write in the same cycle are allowed at any fill level. full is evaluated with the pre-read rd_ptr, which is conservative.

Optional Feature:
ETH_RX_PKT_FIFO_STATS_EN:
- Defined: the drop_cnt port exists. It increments on every drop pulse and saturates at 16'hFFFF.
- Undefined: the port and its counter are absent; drop still pulses.

Decomposition:
- Package eth_pkg holds:
  - ETH_WORD_W=34, ETH_DATA_W=32, ETH_START_BIT=32, ETH_END_BIT=33;
  - typedef enum logic [1:0] {IDLE, WRITE, DROP} pkt_fifo_state_t;
  - typedef logic [33:0] eth_word_t.
- Sub-module eth_fifo_ram: simple dual-port RAM of DEPTH x 34 bits, with a synchronous write and a registered read port.

Test Plan:
- 4-word packet (start on w0, end on w3), rd_en held high -> empty=0 only after w3 is written; pkt_cnt 0->1->0; 4 rd_valid words, the last with bit33=1.
- Single-word packet {end=1, start=1, data=32'hDEADBEEF} -> pkt_cnt=1 the next cycle; read returns 34'h3_DEAD_BEEF.
- DEPTH=64 with 60 committed words, then a 10-word packet -> drop pulses on word 5; pkt_cnt unchanged; the next 3-word packet after draining is accepted intact.
- 70-word packet into an empty FIFO -> dropped; pkt_cnt=0, empty=1, and the following packet is received correctly.
- start asserted mid-packet after 3 words -> first packet dropped (1 pulse); second packet stored intact; pkt_cnt=1.
- rstn asserted mid-packet with 2 packets committed -> empty=1 and pkt_cnt=0 immediately; drop_cnt=0 (STATS_EN); 300 forced drops give drop_cnt=300.
